// File: rtl/noc_to_rxr_if.sv
// Ingress flit port and Avalon-ST egress port of the NoC receive path.
// Both sides use valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both high; a source holds its fields stable while valid=1
// and ready=0.
interface noc_to_rxr_if #(
  parameter int DATA_WIDTH = 512,
  parameter int NOC_WIDTH  = 600
);
  localparam int E = $clog2(DATA_WIDTH/8);

  logic [NOC_WIDTH-1:0]  i_data_in;
  logic                  i_valid_in;
  logic                  i_ready_out;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_sop;
  logic                  out_eop;
  logic [E-1:0]          out_empty;
  logic                  out_error;
  logic                  out_payload;
  logic [31:0]           out_pktid;

  modport slave (
    input  i_data_in, i_valid_in, out_ready,
    output i_ready_out, out_data, out_valid, out_sop, out_eop,
           out_empty, out_error, out_payload, out_pktid
  );

  modport master (
    output i_data_in, i_valid_in, out_ready,
    input  i_ready_out, out_data, out_valid, out_sop, out_eop,
           out_empty, out_error, out_payload, out_pktid
  );
endinterface

// File: rtl/noc_to_rxr.sv
// NoC egress receiver: framing/destination check, show-ahead output FIFO,
// Avalon-ST re-emission and saturating debug counters.
module noc_to_rxr #(
  parameter int DATA_WIDTH = 512,
  parameter int NOC_WIDTH  = 600,
  parameter int NUM_VC     = 2,
  parameter int NOC_RADIX  = 16,
  parameter int NODE_ID    = 4,
  parameter int FIFO_DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  noc_to_rxr_if.slave bus,
  output logic [15:0] o_drop_cnt,
  output logic [15:0] o_err_cnt,
  output logic [15:0] o_pkt_cnt,
  output logic [1:0]  fsm_state
);
  localparam int E         = $clog2(DATA_WIDTH/8);
  localparam int VC_W      = $clog2(NUM_VC);
  localparam int DST_W     = $clog2(NOC_RADIX);
  localparam int ERR_B     = DATA_WIDTH + E;
  localparam int EOP_B     = ERR_B + 1;
  localparam int SOP_B     = ERR_B + 2;
  localparam int PAY_B     = ERR_B + 3;
  localparam int PID_LO    = ERR_B + 4;
  localparam int DST_LO    = PID_LO + 32 + VC_W;
  localparam int FIELD_SUM = DST_LO + DST_W;
  localparam int ENT_W     = DATA_WIDTH + E + 4 + 32;
  localparam int AW        = $clog2(FIFO_DEPTH);

  if (NOC_WIDTH < FIELD_SUM) begin : g_width_check
    $error("noc_to_rxr: NOC_WIDTH too small for the flit fields");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, IN_PKT = 2'd1, DROP_PKT = 2'd2} state_t;

  state_t      state, state_n;
  logic [31:0] cur_pktid;
  logic        cur_payload;

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [ENT_W-1:0] wr_entry, rd_entry;

  logic f_sop, f_eop, f_error, f_payload, dst_hit, accept, pop;
  logic [31:0] f_pktid;
  logic do_push, push_err, latch, drop_inc, err_inc;
  logic unused_flit;

  assign f_error   = bus.i_data_in[ERR_B];
  assign f_eop     = bus.i_data_in[EOP_B];
  assign f_sop     = bus.i_data_in[SOP_B];
  assign f_payload = bus.i_data_in[PAY_B];
  assign f_pktid   = bus.i_data_in[PID_LO +: 32];
  assign dst_hit   = (bus.i_data_in[DST_LO +: DST_W] == DST_W'(NODE_ID));
  // vc and the bits above dst carry nothing this receiver needs.
  assign unused_flit = ^bus.i_data_in;

  // Full is exactly the count MSB because FIFO_DEPTH is a power of two.
  assign bus.i_ready_out = reset & ~count[AW];
  assign accept          = bus.i_valid_in & bus.i_ready_out;
  assign pop             = bus.out_valid & bus.out_ready;

  always_comb begin
    state_n  = state;
    do_push  = 1'b0;
    push_err = 1'b0;
    latch    = 1'b0;
    drop_inc = 1'b0;
    err_inc  = 1'b0;
    if (accept) begin
      if (f_sop) begin
        // A sop outside IDLE means the previous packet never saw its eop.
        if (state != IDLE) err_inc = 1'b1;
        if (dst_hit) begin
          do_push = 1'b1;
          latch   = 1'b1;
          state_n = f_eop ? IDLE : IN_PKT;
        end else begin
          drop_inc = 1'b1;
          state_n  = f_eop ? IDLE : DROP_PKT;
        end
      end else begin
        case (state)
          IN_PKT: begin
            do_push = 1'b1;
            if (f_pktid != cur_pktid) begin
              push_err = 1'b1;
              err_inc  = 1'b1;
            end
            if (f_eop) state_n = IDLE;
          end
          DROP_PKT: begin
            drop_inc = 1'b1;
            if (f_eop) state_n = IDLE;
          end
          default: begin
            drop_inc = 1'b1;
            err_inc  = 1'b1;
          end
        endcase
      end
    end
  end

  // A sop beat takes its sideband from the flit being latched this cycle.
  assign wr_entry = {latch ? f_pktid : cur_pktid,
                     latch ? f_payload : cur_payload,
                     f_sop, f_eop, f_error | push_err,
                     bus.i_data_in[DATA_WIDTH +: E],
                     bus.i_data_in[DATA_WIDTH-1:0]};
  assign rd_entry = mem[rd_ptr];

  assign bus.out_data    = rd_entry[DATA_WIDTH-1:0];
  assign bus.out_empty   = rd_entry[DATA_WIDTH +: E];
  assign bus.out_error   = rd_entry[ERR_B];
  assign bus.out_eop     = rd_entry[EOP_B];
  assign bus.out_sop     = rd_entry[SOP_B];
  assign bus.out_payload = rd_entry[PAY_B];
  assign bus.out_pktid   = rd_entry[PID_LO +: 32];
  assign bus.out_valid   = (count != '0);
  assign fsm_state       = state;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cur_pktid   <= '0;
      cur_payload <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_drop_cnt  <= '0;
      o_err_cnt   <= '0;
      o_pkt_cnt   <= '0;
    end else begin
      state <= state_n;
      if (latch) begin
        cur_pktid   <= f_pktid;
        cur_payload <= f_payload;
      end
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (pop && !do_push) count <= count - 1'b1;
      o_drop_cnt <= sat_inc(o_drop_cnt, drop_inc);
      o_err_cnt  <= sat_inc(o_err_cnt, err_inc);
      o_pkt_cnt  <= sat_inc(o_pkt_cnt, pop & bus.out_eop);
    end
  end
endmodule

// File: tb/tb_noc_to_rxr.sv
// Directed bench for noc_to_rxr: driver tasks push hand-computed beats into a
// scoreboard queue, a negedge monitor pops and compares every delivered beat.
module tb_noc_to_rxr;
  localparam int W = 554;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] o_drop_cnt, o_err_cnt, o_pkt_cnt;
  logic [1:0]  fsm_state;

  noc_to_rxr_if #(.DATA_WIDTH(512), .NOC_WIDTH(600)) bus ();

  noc_to_rxr dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .o_drop_cnt (o_drop_cnt),
    .o_err_cnt  (o_err_cnt),
    .o_pkt_cnt  (o_pkt_cnt),
    .fsm_state  (fsm_state)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int sent   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] pat(input int k);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(k);
    return {16{w}};
  endfunction

  function automatic logic [599:0] make_flit(input logic [3:0] dst, input bit sop, input bit eop,
      input logic [31:0] pid, input bit pay, input logic [5:0] emp, input bit ferr,
      input logic [511:0] d);
    logic [599:0] f;
    f = '0;
    f[511:0]   = d;
    f[517:512] = emp;
    f[518]     = ferr;
    f[519]     = eop;
    f[520]     = sop;
    f[521]     = pay;
    f[553:522] = pid;
    f[554]     = pid[0];
    f[558:555] = dst;
    f[599:559] = {9'h1A5, 32'hDEAD_BEEF};
    return f;
  endfunction

  function automatic logic [W-1:0] beat(input bit sop, input bit eop, input logic [5:0] emp,
      input bit err, input bit pay, input logic [31:0] pid, input logic [511:0] d);
    return {sop, eop, emp, err, pay, pid, d};
  endfunction

  // Drives one flit and returns at posedge+1 after the edge that accepted it.
  task automatic send(input logic [3:0] dst, input bit sop, input bit eop, input logic [31:0] pid,
      input bit pay, input logic [5:0] emp, input bit ferr, input logic [511:0] d);
    int t;
    t = 0;
    bus.i_data_in  = make_flit(dst, sop, eop, pid, pay, emp, ferr, d);
    bus.i_valid_in = 1'b1;
    while (!bus.i_ready_out && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 300) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready stayed %0d, required 1", bus.i_ready_out);
    end else begin
      @(posedge clk); #1;
      sent++;
    end
    bus.i_valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats still outstanding, required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    bus.i_valid_in = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    check("rst_ready", {31'd0, bus.i_ready_out}, 32'd0);
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_drop", {16'd0, o_drop_cnt}, 32'd0);
    check("rst_err", {16'd0, o_err_cnt}, 32'd0);
    check("rst_pkt", {16'd0, o_pkt_cnt}, 32'd0);
    check("rst_state", {30'd0, fsm_state}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      logic [W-1:0] act;
      act = {bus.out_sop, bus.out_eop, bus.out_empty, bus.out_error,
             bus.out_payload, bus.out_pktid, bus.out_data};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got %h, required no beat", act);
      end else begin
        logic [W-1:0] exp;
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL beat: got %h expected %h", act, exp);
        end
      end
    end
  end

  initial begin
    bus.i_data_in  = '0;
    bus.i_valid_in = 1'b0;
    bus.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // 3-flit packet, latency and sideband
    check("lat_idle", {31'd0, bus.out_valid}, 32'd0);
    exp_q.push_back(beat(1, 0, 6'd0, 0, 1, 32'h10, pat(1)));
    send(4'd4, 1, 0, 32'h10, 1, 6'd0, 0, pat(1));
    check("lat_first", {31'd0, bus.out_valid}, 32'd1);
    exp_q.push_back(beat(0, 0, 6'd0, 0, 1, 32'h10, pat(2)));
    send(4'd4, 0, 0, 32'h10, 0, 6'd0, 0, pat(2));
    exp_q.push_back(beat(0, 1, 6'd5, 0, 1, 32'h10, pat(3)));
    send(4'd4, 0, 1, 32'h10, 0, 6'd5, 0, pat(3));
    wait_drain();
    check("pkt_cnt_1", {16'd0, o_pkt_cnt}, 32'd1);

    // backpressure: fill to depth 32 then drain
    do_reset();
    bus.out_ready = 1'b0;
    sent = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          exp_q.push_back(beat(1, 1, 6'(i), 0, i[0], 32'h100 + 32'(i), pat(100 + i)));
          send(4'd4, 1, 1, 32'h100 + 32'(i), i[0], 6'(i), 0, pat(100 + i));
        end
      end
      begin
        repeat (40) @(posedge clk);
        #1;
        check("full_ready", {31'd0, bus.i_ready_out}, 32'd0);
        check("full_accepts", 32'(sent), 32'd32);
        check("full_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("ready_back", {31'd0, bus.i_ready_out}, 32'd1);
      end
    join
    wait_drain();
    check("pkt_cnt_40", {16'd0, o_pkt_cnt}, 32'd40);

    // wrong destination is dropped whole, then a good packet passes
    do_reset();
    send(4'd7, 1, 0, 32'h55, 1, 6'd0, 0, pat(200));
    send(4'd7, 0, 0, 32'h55, 1, 6'd0, 0, pat(201));
    send(4'd7, 0, 0, 32'h55, 1, 6'd0, 0, pat(202));
    send(4'd7, 0, 1, 32'h55, 1, 6'd3, 0, pat(203));
    repeat (3) @(posedge clk);
    #1;
    check("drop_cnt_4", {16'd0, o_drop_cnt}, 32'd4);
    check("drop_state", {30'd0, fsm_state}, 32'd0);
    check("drop_no_beat", {31'd0, bus.out_valid}, 32'd0);
    exp_q.push_back(beat(1, 0, 6'd0, 0, 0, 32'h66, pat(210)));
    send(4'd4, 1, 0, 32'h66, 0, 6'd0, 0, pat(210));
    exp_q.push_back(beat(0, 1, 6'd9, 1, 0, 32'h66, pat(211)));
    send(4'd4, 0, 1, 32'h66, 1, 6'd9, 1, pat(211));
    wait_drain();
    check("pkt_cnt_after_drop", {16'd0, o_pkt_cnt}, 32'd1);

    // pktid mismatch mid-packet, then an orphan flit
    exp_q.push_back(beat(1, 0, 6'd0, 0, 1, 32'h10, pat(300)));
    send(4'd4, 1, 0, 32'h10, 1, 6'd0, 0, pat(300));
    exp_q.push_back(beat(0, 0, 6'd0, 1, 1, 32'h10, pat(301)));
    send(4'd4, 0, 0, 32'h11, 0, 6'd0, 0, pat(301));
    exp_q.push_back(beat(0, 1, 6'd1, 0, 1, 32'h10, pat(302)));
    send(4'd4, 0, 1, 32'h10, 0, 6'd1, 0, pat(302));
    wait_drain();
    check("err_pktid", {16'd0, o_err_cnt}, 32'd1);
    send(4'd4, 0, 1, 32'h10, 0, 6'd0, 0, pat(303));
    @(posedge clk); #1;
    check("orphan_drop", {16'd0, o_drop_cnt}, 32'd5);
    check("orphan_err", {16'd0, o_err_cnt}, 32'd2);

    // sop while IN_PKT truncates the old packet
    exp_q.push_back(beat(1, 0, 6'd0, 0, 0, 32'h20, pat(400)));
    send(4'd4, 1, 0, 32'h20, 0, 6'd0, 0, pat(400));
    exp_q.push_back(beat(1, 0, 6'd0, 0, 1, 32'h21, pat(401)));
    send(4'd4, 1, 0, 32'h21, 1, 6'd0, 0, pat(401));
    exp_q.push_back(beat(0, 1, 6'd2, 0, 1, 32'h21, pat(402)));
    send(4'd4, 0, 1, 32'h21, 0, 6'd2, 0, pat(402));
    wait_drain();
    check("trunc_err", {16'd0, o_err_cnt}, 32'd3);
    check("trunc_pkt", {16'd0, o_pkt_cnt}, 32'd3);

    // reset in the middle of a packet
    bus.out_ready = 1'b0;
    exp_q.push_back(beat(1, 0, 6'd0, 0, 1, 32'h30, pat(500)));
    send(4'd4, 1, 0, 32'h30, 1, 6'd0, 0, pat(500));
    exp_q.push_back(beat(0, 0, 6'd0, 0, 1, 32'h30, pat(501)));
    send(4'd4, 0, 0, 32'h30, 1, 6'd0, 0, pat(501));
    do_reset();
    bus.out_ready = 1'b1;
    send(4'd4, 0, 1, 32'h30, 1, 6'd0, 0, pat(502));
    @(posedge clk); #1;
    check("post_rst_drop", {16'd0, o_drop_cnt}, 32'd1);
    check("post_rst_err", {16'd0, o_err_cnt}, 32'd1);
    check("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);

    // counter saturation with back-to-back orphan flits
    do_reset();
    bus.i_data_in  = make_flit(4'd4, 0, 0, 32'h0, 0, 6'd0, 0, pat(600));
    bus.i_valid_in = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    check("sat_drop_fffe", {16'd0, o_drop_cnt}, 32'hFFFE);
    check("sat_err_fffe", {16'd0, o_err_cnt}, 32'hFFFE);
    repeat (70000 - 65534) @(posedge clk);
    #1;
    bus.i_valid_in = 1'b0;
    check("sat_drop", {16'd0, o_drop_cnt}, 32'hFFFF);
    check("sat_err", {16'd0, o_err_cnt}, 32'hFFFF);
    check("sat_no_beat", {31'd0, bus.out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/noc_to_rxr.md
Name: noc_to_rxr

Overview:
- Receive-side counterpart of the transmit NoC path.
- Consumes flits arriving at this node's NoC egress port and validates packet framing and destination.
- Buffers accepted flits in a show-ahead FIFO and re-emits them as Avalon-ST beats, with payload/header flag and packet ID as sideband, to the downstream parser or DDR writer.
- Maintains saturating drop/error counters for debug.

Parameters:
- DATA_WIDTH, 512, Avalon-ST data width.
- NOC_WIDTH, 600, flit width.
- NUM_VC, 2, NoC virtual channels.
- NOC_RADIX, 16, NoC node count.
- NODE_ID, 4, this node's NoC address; flits with other dst are dropped.
- FIFO_DEPTH, 32, output buffer depth in flits (power of 2).
- E = $clog2(DATA_WIDTH/8) (derived, localparam).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- i_data_in  in  NOC_WIDTH  flit from NoC.
- i_valid_in  in  1  flit valid.
- i_ready_out  out  1  space available; flit accepted when i_valid_in & i_ready_out.
- out_data  out  DATA_WIDTH  beat data.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream ready.
- out_sop  out  1  start of packet.
- out_eop  out  1  end of packet.
- out_empty  out  E  empty bytes on eop beat.
- out_error  out  1  beat error.
- out_payload  out  1  1 = payload packet, 0 = header packet.
- out_pktid  out  32  packet ID.
- o_drop_cnt  out  16  flits dropped (saturating).
- o_err_cnt  out  16  framing/ID errors (saturating).
- o_pkt_cnt  out  16  packets completed at output (saturating).

Behaviour:
- Flit layout, LSB first:
  - data[DATA_WIDTH-1:0], empty[E], error, eop, sop, payload, pktid[32], vc[clog2(NUM_VC)], dst[clog2(NOC_RADIX)].
  - Remaining upper bits are ignored.
  - Elaboration error if NOC_WIDTH is smaller than the field sum (559 at defaults).
- Reset (reset==0 at posedge):
  - FIFO is emptied and FSM goes to IDLE.
  - All counters clear to 0.
  - out_valid=0; i_ready_out=0 during reset.
  - Other outputs are don't-care while out_valid=0.
  - Reset mid-packet discards the partial packet with no error count.
- i_ready_out = (fifo_count < FIFO_DEPTH), from the registered count.
  - When full, no push occurs even if a pop happens in the same cycle; ready reasserts the cycle after the count drops.
- Framing FSM acts on accepted flits only. States IDLE, IN_PKT, DROP_PKT; registers cur_pktid and cur_payload.
- IDLE:
  - sop=1 and dst==NODE_ID: push, latch pktid/payload. eop=1 -> stay IDLE (single-flit packet); else -> IN_PKT.
  - sop=1 and dst!=NODE_ID: no push, drop_cnt++. -> DROP_PKT unless eop=1.
  - sop=0: no push, drop_cnt++, err_cnt++. Stay IDLE.
- IN_PKT:
  - sop=0: push. If pktid!=cur_pktid, the pushed beat has error forced to 1 and err_cnt++. eop=1 -> IDLE.
  - sop=1: err_cnt++ (previous packet truncated). The flit is then treated as in IDLE: push or drop per dst, re-latch.
- DROP_PKT:
  - sop=0: drop_cnt++. eop=1 -> IDLE.
  - sop=1: err_cnt++, then handle as in IDLE.
- vc field is ignored; both VCs are treated identically.
- Pushed beats carry out_payload/out_pktid from the latched registers, not from the per-flit fields.
- Output handshake:
  - Show-ahead FIFO; a beat pushed at edge N is visible on out_valid after edge N (latency 1).
  - Pop when out_valid & out_ready.
  - Output fields are stable while out_valid=1 & out_ready=0.
- o_pkt_cnt increments on each popped beat with eop=1.
- Counters hold at 16'hFFFF once reached.
- Simultaneous push and pop with the FIFO not full: count unchanged, order preserved.

Test Plan:
- 3-flit packet, dst=4, pktid=0x10, payload=1, out_ready=1. Expect 3 beats: sop on beat 0, eop with empty=5 on beat 2, out_pktid=0x10, out_payload=1, first out_valid 1 cycle after first accept, o_pkt_cnt=1.
- out_ready=0, stream 40 single-flit packets. Expect i_ready_out to drop after 32 accepts and no flit lost; then out_ready=1 drains 32 beats in order, ready reasserts, and all 40 are delivered, o_pkt_cnt=40.
- Packet with dst=7, 4 flits. Expect no output beats, o_drop_cnt=4, FSM back in IDLE; next valid packet passes unchanged.
- Mid-packet flit with pktid=0x11 against latched 0x10. Expect that beat with out_error=1, o_err_cnt=1. Orphan non-sop flit in IDLE: o_drop_cnt+1, o_err_cnt+1.
- sop arrives while IN_PKT (no eop seen). Expect o_err_cnt+1 and the new packet delivered with the new pktid. reset=0 asserted mid-packet for 1 cycle: FIFO empty, counters 0, out_valid=0 on the next cycle.
- Force 70000 orphan flits. Expect o_drop_cnt and o_err_cnt to saturate at 0xFFFF.
